// File: rtl/bsg_decode_credit_dispatch_pkg.sv
// Width helpers shared by the credit-dispatch decoder and its credit counters.
package bsg_decode_credit_dispatch_pkg;

    // Destination index width; a single destination still needs one bit.
    function automatic int unsigned lg_num_out(input int unsigned num_out);
        return (num_out <= 1) ? 1 : $clog2(num_out);
    endfunction

    // Counter width able to hold 0..credits inclusive.
    function automatic int unsigned lg_credits(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/bsg_decode_credit_dispatch_ctr.sv
// One saturating up/down credit counter, reset to credits_p.
module bsg_decode_credit_dispatch_ctr #(
    parameter int unsigned credits_p = 4,
    parameter int unsigned width_p   = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o,
    output logic               nonzero_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(credits_p);

    logic [width_p-1:0] r_count;
    logic [width_p-1:0] w_count_next;

    // Simultaneous up and down cancel; a return to a full counter is dropped.
    always_comb begin
        w_count_next = r_count;
        if (up_i && !down_i) begin
            if (r_count != max_lp) w_count_next = r_count + width_p'(1);
        end else if (down_i && !up_i) begin
            if (r_count != '0) w_count_next = r_count - width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_count <= max_lp;
        else         r_count <= w_count_next;
    end

    assign count_o   = r_count;
    assign nonzero_o = (r_count != '0);

endmodule

// File: rtl/bsg_decode_credit_dispatch.sv
// Registered one-hot decoder with per-destination credits and a single output slot.
// Define BSG_DECODE_CREDIT_DISPATCH_ASSERT_EN to compile simulation-only protocol checks.
module bsg_decode_credit_dispatch
    import bsg_decode_credit_dispatch_pkg::*;
#(
    parameter  int unsigned num_out_p     = 16,
    parameter  int unsigned credits_p     = 4,
    localparam int unsigned lg_num_out_lp = lg_num_out(num_out_p),
    localparam int unsigned lg_credits_lp = lg_credits(credits_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [lg_num_out_lp-1:0] dest_i,
    output logic                     ready_o,
    output logic [num_out_p-1:0]     v_o,
    input  logic                     yumi_i,
    input  logic [num_out_p-1:0]     credit_return_i,
    output logic [num_out_p-1:0]     credit_avail_o,
    output logic                     idle_o
);

    logic                     w_full;
    logic                     w_slot_free;
    logic                     w_dest_ok;
    logic                     w_accept;
    logic [num_out_p-1:0]     w_dest_onehot;
    logic [num_out_p-1:0]     w_nonzero;
    logic [num_out_p-1:0]     w_consume;
    logic [num_out_p-1:0]     w_at_max;
    logic [num_out_p-1:0]     w_v_next;
    logic [num_out_p-1:0]     r_v_o;
    logic [lg_credits_lp-1:0] w_count [num_out_p];

    // Out-of-range indices match no bit, so they can never be accepted.
    always_comb begin
        w_dest_onehot = '0;
        for (int unsigned k = 0; k < num_out_p; k++) begin
            w_dest_onehot[k] = (32'(dest_i) == k);
        end
    end

    assign w_full      = |r_v_o;
    assign w_slot_free = ~w_full | yumi_i;
    assign w_dest_ok   = |(w_dest_onehot & w_nonzero);
    assign ready_o     = w_slot_free & w_dest_ok;
    assign w_accept    = v_i & ready_o;
    assign w_consume   = w_accept ? w_dest_onehot : '0;

    // Output slot: load on accept, clear on yumi, otherwise hold.
    always_comb begin
        w_v_next = r_v_o;
        if (w_accept)    w_v_next = w_dest_onehot;
        else if (yumi_i) w_v_next = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_v_o <= '0;
        else         r_v_o <= w_v_next;
    end

    genvar g;
    generate
        for (g = 0; g < num_out_p; g++) begin : g_ctr
            bsg_decode_credit_dispatch_ctr #(
                .credits_p (credits_p),
                .width_p   (lg_credits_lp)
            ) u_ctr (
                .clk_i     (clk_i),
                .reset_i   (reset_i),
                .up_i      (credit_return_i[g]),
                .down_i    (w_consume[g]),
                .count_o   (w_count[g]),
                .nonzero_o (w_nonzero[g])
            );
            assign w_at_max[g] = (w_count[g] == lg_credits_lp'(credits_p));
        end
    endgenerate

    assign v_o            = r_v_o;
    assign credit_avail_o = w_nonzero;
    assign idle_o         = ~w_full & (&w_at_max);

`ifdef BSG_DECODE_CREDIT_DISPATCH_ASSERT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (|(credit_return_i & w_at_max))
                $error("credit return to a full counter: %b", credit_return_i & w_at_max);
            if (yumi_i && !w_full)
                $error("yumi_i asserted with no valid output");
            if (v_i && (32'(dest_i) >= num_out_p))
                $error("request to out-of-range destination %0d", dest_i);
            if ((r_v_o & (r_v_o - num_out_p'(1))) != '0)
                $error("v_o not one-hot: %b", r_v_o);
        end
    end
`else
    // Protocol checks compiled out; saturate/ignore behaviour is unchanged.
`endif

endmodule

// File: tb/tb_bsg_decode_credit_dispatch.sv
// Table-driven bench with a v_o scoreboard for the credit-dispatch decoder (16 and 12 destinations).
module tb_bsg_decode_credit_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v;
    logic [3:0]  dest;
    logic        yumi;
    logic [15:0] ret;
    logic        ready;
    logic [15:0] v_o;
    logic [15:0] avail;
    logic        idle;

    logic        b_v;
    logic [3:0]  b_dest;
    logic        b_yumi;
    logic [11:0] b_ret;
    logic        b_ready;
    logic [11:0] b_v_o;
    logic [11:0] b_avail;
    logic        b_idle;

    bsg_decode_credit_dispatch #(.num_out_p(16), .credits_p(4)) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v), .dest_i(dest), .ready_o(ready),
        .v_o(v_o), .yumi_i(yumi), .credit_return_i(ret), .credit_avail_o(avail),
        .idle_o(idle)
    );

    bsg_decode_credit_dispatch #(.num_out_p(12), .credits_p(4)) dut12 (
        .clk_i(clk), .reset_i(reset), .v_i(b_v), .dest_i(b_dest), .ready_o(b_ready),
        .v_o(b_v_o), .yumi_i(b_yumi), .credit_return_i(b_ret), .credit_avail_o(b_avail),
        .idle_o(b_idle)
    );

    typedef struct {
        logic        v;
        logic [3:0]  dest;
        logic        yumi;
        logic [15:0] ret;
        logic        exp_ready;
        logic [15:0] exp_avail;
        logic        exp_idle;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vv, input logic [3:0] d, input logic y,
                                input logic [15:0] r, input logic er,
                                input logic [15:0] ea, input logic ei);
        vec_t t;
        t.v = vv; t.dest = d; t.yumi = y; t.ret = r;
        t.exp_ready = er; t.exp_avail = ea; t.exp_idle = ei;
        return t;
    endfunction

    // Drive one cycle at the falling edge, check ready before the edge and state after it.
    task automatic step(input vec_t r, input int idx);
        logic [15:0] exp_v;
        @(negedge clk);
        v = r.v; dest = r.dest; yumi = r.yumi; ret = r.ret;
        #1;
        chk($sformatf("ready[%0d]", idx), 32'(ready), 32'(r.exp_ready));
        if (r.yumi && sb_q.size() > 0) void'(sb_q.pop_front());
        if (r.v && r.exp_ready) sb_q.push_back(16'(1) << r.dest);
        @(posedge clk);
        #1;
        exp_v = (sb_q.size() > 0) ? sb_q[0] : 16'h0000;
        chk($sformatf("v_o[%0d]", idx), 32'(v_o), 32'(exp_v));
        chk($sformatf("avail[%0d]", idx), 32'(avail), 32'(r.exp_avail));
        chk($sformatf("idle[%0d]", idx), 32'(idle), 32'(r.exp_idle));
    endtask

    initial begin
        reset = 1'b1; v = 1'b0; dest = '0; yumi = 1'b0; ret = '0;
        b_v = 1'b0; b_dest = '0; b_yumi = 1'b0; b_ret = '0;

        // dest 5 issue and hold until yumi
        vecs.push_back(mk(1,  5, 0, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0000, 0, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0000, 0, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0020, 1, 16'hFFFF, 1));
        // drain dest 3 back-to-back, stall at zero, return
        vecs.push_back(mk(1,  3, 0, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  3, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  3, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  3, 1, 16'h0000, 1, 16'hFFF7, 0));
        vecs.push_back(mk(1,  3, 1, 16'h0000, 0, 16'hFFF7, 0));
        vecs.push_back(mk(1,  3, 0, 16'h0008, 0, 16'hFFFF, 0));
        vecs.push_back(mk(1,  3, 0, 16'h0000, 1, 16'hFFF7, 0));
        vecs.push_back(mk(0,  0, 1, 16'h0008, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0008, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0008, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0008, 1, 16'hFFFF, 1));
        // dest 7: same-cycle return at zero, then accept+return nets out
        vecs.push_back(mk(1,  7, 0, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  7, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  7, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  7, 1, 16'h0000, 1, 16'hFF7F, 0));
        vecs.push_back(mk(1,  7, 1, 16'h0080, 0, 16'hFFFF, 0));
        vecs.push_back(mk(1,  7, 0, 16'h0000, 1, 16'hFF7F, 0));
        vecs.push_back(mk(0,  0, 1, 16'h0080, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  7, 0, 16'h0080, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  7, 1, 16'h0000, 1, 16'hFF7F, 0));
        vecs.push_back(mk(0,  0, 1, 16'h0080, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0080, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0080, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0080, 1, 16'hFFFF, 1));
        // full slot with yumi takes dest 15 with no bubble
        vecs.push_back(mk(1,  0, 0, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1, 15, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 1, 16'h0001, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h8000, 1, 16'hFFFF, 1));
        // overflow return to full counter 2, then prove it still holds exactly 4
        vecs.push_back(mk(0,  0, 0, 16'h0004, 1, 16'hFFFF, 1));
        vecs.push_back(mk(1,  2, 0, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  2, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  2, 1, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk(1,  2, 1, 16'h0000, 1, 16'hFFFB, 0));
        vecs.push_back(mk(1,  2, 1, 16'h0000, 0, 16'hFFFB, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0004, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0004, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0004, 1, 16'hFFFF, 0));
        vecs.push_back(mk(0,  0, 0, 16'h0004, 1, 16'hFFFF, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_v_o", 32'(v_o), 32'h0);
        chk("rst_avail", 32'(avail), 32'hFFFF);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_avail12", 32'(b_avail), 32'hFFF);
        chk("rst_v_o12", 32'(b_v_o), 32'h0);

        foreach (vecs[i]) step(vecs[i], i);

        // reset while v_o holds dest 10 with one credit left
        step(mk(1, 10, 0, 16'h0000, 1, 16'hFFFF, 0), 100);
        step(mk(1, 10, 1, 16'h0000, 1, 16'hFFFF, 0), 101);
        step(mk(1, 10, 1, 16'h0000, 1, 16'hFFFF, 0), 102);
        @(negedge clk);
        reset = 1'b1; v = 1'b0; yumi = 1'b0; ret = '0;
        @(posedge clk);
        #1;
        sb_q.delete();
        chk("midrst_v_o", 32'(v_o), 32'h0);
        chk("midrst_avail", 32'(avail), 32'hFFFF);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_idle", 32'(idle), 32'h1);
        chk("postrst_v_o", 32'(v_o), 32'h0);

        // 12-destination instance: out-of-range index never ready
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_dest = 4'd13;
            #1;
            chk($sformatf("oor_ready12[%0d]", i), 32'(b_ready), 32'h0);
        end
        @(negedge clk);
        b_dest = 4'd11;
        #1;
        chk("ready12_d11", 32'(b_ready), 32'h1);
        chk("idle12", 32'(b_idle), 32'h1);

        // extra return to full counter 2 saturates: exactly 4 accepts then stall
        b_ret = 12'h004;
        @(posedge clk);
        @(negedge clk);
        b_ret = '0;
        #1;
        chk("sat_avail12", 32'(b_avail), 32'hFFF);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            b_v = 1'b1; b_dest = 4'd2; b_yumi = (i != 0);
            #1;
            chk($sformatf("sat_ready12[%0d]", i), 32'(b_ready), 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("sat_v_o12[%0d]", i), 32'(b_v_o), 32'h004);
        end
        @(negedge clk);
        b_v = 1'b1; b_yumi = 1'b1;
        #1;
        chk("sat_stall12", 32'(b_ready), 32'h0);
        chk("sat_avail12_0", 32'(b_avail), 32'hFFB);
        @(posedge clk);
        #1;
        chk("sat_v_o12_clr", 32'(b_v_o), 32'h0);
        @(negedge clk);
        b_v = 1'b0; b_yumi = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
